// File: rtl/reorder_buffer_pkg.sv
// Shared widths, null encodings and instruction types for the reorder buffer
// and the blocks that talk to it.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int TAG_W = IDX_W + 1;
  localparam int REG_W = 6;

  localparam logic [TAG_W-1:0] ENTRY_NULL = TAG_W'(ROB_DEPTH);
  localparam logic [REG_W-1:0] REG_NULL = 6'd32;

  typedef enum logic [1:0] {
    TYPE_ALU    = 2'b00,
    TYPE_BRANCH = 2'b01,
    TYPE_STORE  = 2'b10,
    TYPE_LOAD   = 2'b11
  } rob_type_e;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates on issue, collects ALU/LSB results,
// retires the head in program order and flushes on a branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [5:0]       issue_rd,
  input  logic [1:0]       issue_type,
  input  logic [31:0]      issue_pc,
  input  logic             issue_pred,
  output logic             rob_full,
  output logic [TAG_W-1:0] rob_new_entry,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [31:0]      alu_value,
  input  logic             alu_taken,
  input  logic [31:0]      alu_target,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [31:0]      lsb_value,
  input  logic [TAG_W-1:0] qj_tag,
  input  logic [TAG_W-1:0] qk_tag,
  output logic             qj_ready,
  output logic             qk_ready,
  output logic [31:0]      qj_value,
  output logic [31:0]      qk_value,
  output logic             commit_sgn,
  output logic [TAG_W-1:0] commit_entry,
  output logic [5:0]       commit_rd,
  output logic [31:0]      commit_result,
  output logic             store_commit,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);

  // Issue handshake: the decoder holds issue_valid with its payload; the entry
  // is taken on a clock edge where rdy=1, rob_full=0 and rollback=0, and its
  // tag is the rob_new_entry value visible during that same cycle.

  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [IDX_W:0]       count;
  logic [IDX_W:0]       count_next;
  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] ready;
  logic [ROB_DEPTH-1:0] pred_q;
  logic [ROB_DEPTH-1:0] taken_q;
  rob_type_e            type_q   [ROB_DEPTH];
  logic [5:0]           rd_q     [ROB_DEPTH];
  logic [31:0]          pc_q     [ROB_DEPTH];
  logic [31:0]          value_q  [ROB_DEPTH];
  logic [31:0]          target_q [ROB_DEPTH];

  logic issue_fire;
  logic commit_fire;
  logic mispredict;
  logic alu_wb;
  logic lsb_wb;

  assign rob_new_entry = {1'b0, tail};

  assign issue_fire  = rdy & issue_valid & ~rob_full & ~rollback;
  // Commit looks only at the registered ready bit, so a result written this
  // cycle retires on the next one.
  assign commit_fire = rdy & busy[head] & ready[head];
  assign mispredict  = (type_q[head] == TYPE_BRANCH) && (taken_q[head] != pred_q[head]);
  assign alu_wb = alu_valid & ~alu_tag[IDX_W] & busy[alu_tag[IDX_W-1:0]];
  assign lsb_wb = lsb_valid & ~lsb_tag[IDX_W] & busy[lsb_tag[IDX_W-1:0]];

  always_comb begin
    count_next = count;
    if (issue_fire && !commit_fire) count_next = count + 1'b1;
    else if (!issue_fire && commit_fire) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rob_full      <= 1'b0;
      busy          <= '0;
      ready         <= '0;
      commit_sgn    <= 1'b0;
      store_commit  <= 1'b0;
      rollback      <= 1'b0;
      commit_entry  <= ENTRY_NULL;
      commit_rd     <= REG_NULL;
      commit_result <= '0;
      rollback_pc   <= '0;
    end else if (!rdy) begin
      commit_sgn   <= 1'b0;
      store_commit <= 1'b0;
      rollback     <= 1'b0;
    end else begin
      commit_sgn   <= commit_fire;
      store_commit <= commit_fire && (type_q[head] == TYPE_STORE);
      rollback     <= commit_fire && mispredict;

      if (alu_wb) begin
        value_q[alu_tag[IDX_W-1:0]]  <= alu_value;
        taken_q[alu_tag[IDX_W-1:0]]  <= alu_taken;
        target_q[alu_tag[IDX_W-1:0]] <= alu_target;
        ready[alu_tag[IDX_W-1:0]]    <= 1'b1;
      end
      if (lsb_wb) begin
        value_q[lsb_tag[IDX_W-1:0]] <= lsb_value;
        ready[lsb_tag[IDX_W-1:0]]   <= 1'b1;
      end

      if (commit_fire) begin
        commit_entry  <= {1'b0, head};
        commit_rd     <= mispredict ? REG_NULL : rd_q[head];
        commit_result <= value_q[head];
        busy[head]    <= 1'b0;
        ready[head]   <= 1'b0;
        head          <= head + 1'b1;
        if (mispredict) rollback_pc <= taken_q[head] ? target_q[head] : pc_q[head] + 32'd4;
      end

      if (issue_fire) begin
        busy[tail]   <= 1'b1;
        ready[tail]  <= 1'b0;
        type_q[tail] <= rob_type_e'(issue_type);
        rd_q[tail]   <= issue_rd;
        pc_q[tail]   <= issue_pc;
        pred_q[tail] <= issue_pred;
        tail         <= tail + 1'b1;
      end

      count    <= count_next;
      rob_full <= (count_next == (IDX_W+1)'(ROB_DEPTH));

      // A mispredict squashes every younger entry, including one issued this cycle.
      if (commit_fire && mispredict) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        rob_full <= 1'b0;
        busy     <= '0;
        ready    <= '0;
      end
    end
  end

  always_comb begin
    qj_ready = 1'b0;
    qj_value = '0;
    if (qj_tag == ENTRY_NULL) begin
      qj_ready = 1'b1;
    end else if (!qj_tag[IDX_W] && ready[qj_tag[IDX_W-1:0]]) begin
      qj_ready = 1'b1;
      qj_value = value_q[qj_tag[IDX_W-1:0]];
    end else if (alu_valid && alu_tag == qj_tag) begin
      qj_ready = 1'b1;
      qj_value = alu_value;
    end else if (lsb_valid && lsb_tag == qj_tag) begin
      qj_ready = 1'b1;
      qj_value = lsb_value;
    end
  end

  always_comb begin
    qk_ready = 1'b0;
    qk_value = '0;
    if (qk_tag == ENTRY_NULL) begin
      qk_ready = 1'b1;
    end else if (!qk_tag[IDX_W] && ready[qk_tag[IDX_W-1:0]]) begin
      qk_ready = 1'b1;
      qk_value = value_q[qk_tag[IDX_W-1:0]];
    end else if (alu_valid && alu_tag == qk_tag) begin
      qk_ready = 1'b1;
      qk_value = alu_value;
    end else if (lsb_valid && lsb_tag == qk_tag) begin
      qk_ready = 1'b1;
      qk_value = lsb_value;
    end
  end

endmodule
